// File: rtl/alarm_key_conditioner_if.sv
// Board-side key/switch inputs and the six CPU PIO exports of the alarm-clock key front end.
interface alarm_key_conditioner_if;
  logic key_hours_n;
  logic key_minutes_n;
  logic key_off_n;
  logic key_set_alarm_n;
  logic key_set_clock_n;
  logic sw_reset;
  logic hours_export;
  logic minutes_export;
  logic off_export;
  logic set_alarm_export;
  logic set_clock_export;
  logic switch_reset_export;

  modport master (
    output key_hours_n, key_minutes_n, key_off_n, key_set_alarm_n, key_set_clock_n, sw_reset,
    input  hours_export, minutes_export, off_export, set_alarm_export, set_clock_export,
           switch_reset_export
  );

  modport slave (
    input  key_hours_n, key_minutes_n, key_off_n, key_set_alarm_n, key_set_clock_n, sw_reset,
    output hours_export, minutes_export, off_export, set_alarm_export, set_clock_export,
           switch_reset_export
  );
endinterface

// File: rtl/alarm_key_conditioner.sv
// Key front end: per-key 2-flop sync + debounce, clean levels for off/set/switch and
// stretched, auto-repeating strobes for hours/minutes.

module akc_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic clk_clk,
  input  logic reset_reset_n,
  input  logic raw,
  output logic stable
);
  localparam int W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic REL = ACTIVE_LOW ? 1'b1 : 1'b0;

  logic [1:0]   sync;
  logic [W-1:0] cnt;
  logic         pressed;

  // Polarity is normalised only after the second flop so sync resets to "released".
  assign pressed = sync[1] ^ REL;

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      sync   <= {2{REL}};
      cnt    <= '0;
      stable <= 1'b0;
    end else begin
      sync <= {sync[0], raw};
      if (pressed == stable) begin
        cnt <= '0;
      end else if (cnt == W'(DEBOUNCE_CYCLES - 1)) begin
        stable <= pressed;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

module akc_strobe #(
  parameter int STRETCH_CYCLES       = 500000,
  parameter int REPEAT_DELAY_CYCLES  = 25000000,
  parameter int REPEAT_PERIOD_CYCLES = 10000000
) (
  input  logic clk_clk,
  input  logic reset_reset_n,
  input  logic press,
  output logic strobe
);
  localparam int HW = $clog2(REPEAT_DELAY_CYCLES);
  localparam int SW = (STRETCH_CYCLES > 1) ? $clog2(STRETCH_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, DELAY, REPEAT} state_t;

  state_t        state;
  logic [HW-1:0] hcnt;
  logic [SW-1:0] scnt;
  logic          fire;

  // Release outranks a coincident terminal count: fire requires press still held.
  always_comb begin
    fire = 1'b0;
    case (state)
      IDLE:    fire = press;
      DELAY:   fire = press && (hcnt == HW'(REPEAT_DELAY_CYCLES - 1));
      REPEAT:  fire = press && (hcnt == HW'(REPEAT_PERIOD_CYCLES - 1));
      default: fire = 1'b0;
    endcase
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state  <= IDLE;
      hcnt   <= '0;
      scnt   <= '0;
      strobe <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          hcnt <= '0;
          if (press) state <= DELAY;
        end
        DELAY: begin
          if (!press) begin
            state <= IDLE;
            hcnt  <= '0;
          end else if (fire) begin
            state <= REPEAT;
            hcnt  <= '0;
          end else begin
            hcnt <= hcnt + 1'b1;
          end
        end
        REPEAT: begin
          if (!press) begin
            state <= IDLE;
            hcnt  <= '0;
          end else if (fire) begin
            hcnt <= '0;
          end else begin
            hcnt <= hcnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          hcnt  <= '0;
        end
      endcase

      // A strobe in flight always completes at full width, even after release.
      if (fire) begin
        strobe <= 1'b1;
        scnt   <= SW'(STRETCH_CYCLES - 1);
      end else if (scnt != '0) begin
        scnt <= scnt - 1'b1;
      end else begin
        strobe <= 1'b0;
      end
    end
  end
endmodule

module alarm_key_conditioner #(
  parameter int DEBOUNCE_CYCLES      = 1000000,
  parameter int STRETCH_CYCLES       = 500000,
  parameter int REPEAT_DELAY_CYCLES  = 25000000,
  parameter int REPEAT_PERIOD_CYCLES = 10000000
) (
  input  logic                    clk_clk,
  input  logic                    reset_reset_n,
  alarm_key_conditioner_if.slave  io
);
  // Channel order: hours, minutes, off, set_alarm, set_clock, switch_reset.
  localparam int         NUM_KEYS     = 6;
  localparam logic [5:0] ACT_LOW_MASK = 6'b011111;

  if (!(STRETCH_CYCLES < REPEAT_PERIOD_CYCLES && REPEAT_PERIOD_CYCLES < REPEAT_DELAY_CYCLES))
  begin : g_param_err
    $error("alarm_key_conditioner: need STRETCH < REPEAT_PERIOD < REPEAT_DELAY");
  end

  logic [NUM_KEYS-1:0] key_raw;
  logic [NUM_KEYS-1:0] key_stable;
  logic [1:0]          strobe;
  logic [3:0]          level_q;

  assign key_raw = {io.sw_reset, io.key_set_clock_n, io.key_set_alarm_n,
                    io.key_off_n, io.key_minutes_n, io.key_hours_n};

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_db
    akc_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .ACTIVE_LOW      (ACT_LOW_MASK[i])
    ) u_db (
      .clk_clk       (clk_clk),
      .reset_reset_n (reset_reset_n),
      .raw           (key_raw[i]),
      .stable        (key_stable[i])
    );
  end

  for (genvar i = 0; i < 2; i++) begin : g_strobe
    akc_strobe #(
      .STRETCH_CYCLES       (STRETCH_CYCLES),
      .REPEAT_DELAY_CYCLES  (REPEAT_DELAY_CYCLES),
      .REPEAT_PERIOD_CYCLES (REPEAT_PERIOD_CYCLES)
    ) u_strobe (
      .clk_clk       (clk_clk),
      .reset_reset_n (reset_reset_n),
      .press         (key_stable[i]),
      .strobe        (strobe[i])
    );
  end

  // Extra register keeps level latency equal to the strobe rise latency.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) level_q <= '0;
    else                level_q <= key_stable[5:2];
  end

  assign io.hours_export        = strobe[0];
  assign io.minutes_export      = strobe[1];
  assign io.off_export          = level_q[0];
  assign io.set_alarm_export    = level_q[1];
  assign io.set_clock_export    = level_q[2];
  assign io.switch_reset_export = level_q[3];
endmodule

// File: tb/tb_alarm_key_conditioner.sv
// Directed bench for alarm_key_conditioner with shortened timing parameters.
module tb_alarm_key_conditioner;
  localparam int DB = 8, ST = 4, RD = 40, RP = 10;

  logic clk_clk = 1'b0;
  logic reset_reset_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk_clk = ~clk_clk;

  alarm_key_conditioner_if io ();

  alarm_key_conditioner #(
    .DEBOUNCE_CYCLES      (DB),
    .STRETCH_CYCLES       (ST),
    .REPEAT_DELAY_CYCLES  (RD),
    .REPEAT_PERIOD_CYCLES (RP)
  ) dut (
    .clk_clk       (clk_clk),
    .reset_reset_n (reset_reset_n),
    .io            (io)
  );

  typedef struct packed {
    logic [5:0]      mask;
    logic [7:0]      bounce;
    logic [7:0]      low;
    logic [7:0]      window;
    logic [2:0]      exp_n;
    logic [4:0][7:0] exp_rise;
    logic [7:0]      exp_w;
  } vec_t;

  vec_t vecs [7];

  function automatic vec_t mk(input logic [5:0] m, input int b, input int l, input int w,
                              input int n, input int r0, input int r1, input int r2,
                              input int r3, input int r4, input int pw);
    vec_t v;
    v.mask     = m;
    v.bounce   = 8'(b);
    v.low      = 8'(l);
    v.window   = 8'(w);
    v.exp_n    = 3'(n);
    v.exp_rise = {8'(r4), 8'(r3), 8'(r2), 8'(r1), 8'(r0)};
    v.exp_w    = 8'(pw);
    return v;
  endfunction

  function automatic logic [5:0] outs();
    return {io.switch_reset_export, io.set_clock_export, io.set_alarm_export,
            io.off_export, io.minutes_export, io.hours_export};
  endfunction

  task automatic drive(input logic [5:0] act);
    io.key_hours_n     = ~act[0];
    io.key_minutes_n   = ~act[1];
    io.key_off_n       = ~act[2];
    io.key_set_alarm_n = ~act[3];
    io.key_set_clock_n = ~act[4];
    io.sw_reset        =  act[5];
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic settle(input int n);
    drive(6'b0);
    repeat (n) @(posedge clk_clk);
    @(negedge clk_clk);
  endtask

  // t counts posedges after the edge at which the raw inputs change; samples on negedge.
  task automatic run_vec(input int idx, input vec_t v);
    int         nr   [6];
    int         rise [6][8];
    int         wid  [6][8];
    logic [5:0] prev, cur;
    int         quiet;
    quiet = 1;
    for (int b = 0; b < int'(v.bounce); b++) begin
      @(posedge clk_clk); #1;
      drive(((b / 3) % 2 == 0) ? v.mask : 6'b0);
      @(negedge clk_clk);
      if (outs() != 6'b0) quiet = 0;
    end
    if (v.bounce != 0) chk($sformatf("v%0d bounce_quiet", idx), quiet, 1);
    for (int c = 0; c < 6; c++) begin
      nr[c] = 0;
      for (int k = 0; k < 8; k++) begin rise[c][k] = 0; wid[c][k] = 0; end
    end
    @(posedge clk_clk); #1;
    drive(v.mask);
    prev = outs();
    for (int t = 1; t <= int'(v.window); t++) begin
      @(posedge clk_clk); #1;
      if (t == int'(v.low)) drive(6'b0);
      @(negedge clk_clk);
      cur = outs();
      for (int c = 0; c < 6; c++) begin
        if (cur[c] && !prev[c] && nr[c] < 8) begin
          rise[c][nr[c]] = t;
          nr[c]++;
        end
        if (cur[c] && nr[c] > 0) wid[c][nr[c]-1]++;
      end
      prev = cur;
    end
    for (int c = 0; c < 6; c++) begin
      int en;
      en = v.mask[c] ? int'(v.exp_n) : 0;
      chk($sformatf("v%0d ch%0d pulse_count", idx, c), nr[c], en);
      for (int k = 0; k < en && k < nr[c]; k++) begin
        chk($sformatf("v%0d ch%0d rise%0d", idx, c, k), rise[c][k], int'(v.exp_rise[k]));
        chk($sformatf("v%0d ch%0d width%0d", idx, c, k), wid[c][k], int'(v.exp_w));
      end
    end
  endtask

  // Hold hours into REPEAT, hit reset while a strobe is high, then watch re-acceptance.
  task automatic reset_mid_op();
    int t, r, nr, got_hi;
    int rise [2];
    logic prev;
    @(posedge clk_clk); #1;
    drive(6'b000001);
    t = 0; r = 0;
    while (r < 2 && t < 100) begin
      @(posedge clk_clk); t++;
      @(negedge clk_clk);
      if (io.hours_export && !prev) r++;
      prev = io.hours_export;
    end
    chk("rst second_rise_time", t, 51);
    @(posedge clk_clk); #1;
    got_hi = int'(io.hours_export);
    chk("rst hours_high_before", got_hi, 1);
    reset_reset_n = 1'b0;
    #1;
    chk("rst outputs_async_zero", int'(outs()), 0);
    repeat (3) @(posedge clk_clk);
    @(negedge clk_clk);
    chk("rst outputs_held_zero", int'(outs()), 0);
    @(posedge clk_clk); #1;
    reset_reset_n = 1'b1;
    nr = 0; prev = 1'b0; rise[0] = 0; rise[1] = 0;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk_clk);
      @(negedge clk_clk);
      if (io.hours_export && !prev && nr < 2) begin rise[nr] = k; nr++; end
      prev = io.hours_export;
    end
    chk("rst post_pulse_count", nr, 2);
    chk("rst post_first_rise", rise[0], 11);
    chk("rst post_repeat_gap", rise[1] - rise[0], RD);
    settle(40);
  endtask

  initial begin
    vecs[0] = mk(6'b000001, 30, 20,  60, 1, 11,  0,  0,  0,  0,  4); // bounce then hold hours
    vecs[1] = mk(6'b000010,  0, 75, 130, 5, 11, 51, 61, 71, 81,  4); // minutes auto-repeat
    vecs[2] = mk(6'b010000,  0,  7,  40, 0,  0,  0,  0,  0,  0,  0); // 7-cycle glitch
    vecs[3] = mk(6'b000100,  0, 30,  60, 1, 11,  0,  0,  0,  0, 30); // off level
    vecs[4] = mk(6'b100000,  0, 50,  80, 1, 11,  0,  0,  0,  0, 50); // switch level
    vecs[5] = mk(6'b001000,  0,  8,  40, 1, 11,  0,  0,  0,  0,  8); // exactly DB cycles accepted
    vecs[6] = mk(6'b000011,  0, 60, 100, 3, 11, 51, 61,  0,  0,  4); // both, release hits fire

    drive(6'b0);
    reset_reset_n = 1'b0;
    repeat (3) @(posedge clk_clk);
    @(negedge clk_clk);
    chk("reset outputs_zero", int'(outs()), 0);
    @(posedge clk_clk); #1;
    reset_reset_n = 1'b1;
    repeat (20) @(posedge clk_clk);
    @(negedge clk_clk);
    chk("idle outputs_zero", int'(outs()), 0);

    for (int i = 0; i < 7; i++) begin
      run_vec(i, vecs[i]);
      settle(30);
    end

    reset_mid_op();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end
endmodule
